// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared Kogge-Stone prefix types and combine operator
package ks_pkg;

    localparam int KS_MAX_WIDTH = 64;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Black cell: merge a higher group with the adjacent lower group.
    function automatic pg_t ks_black(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// rtl/ks_prefix_level.sv - one registered Kogge-Stone prefix level of span DIST
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_i,
    input  pg_t [WIDTH-1:0]  pg_i,
    output logic             valid_o,
    output pg_t [WIDTH-1:0]  pg_o
);

    pg_t [WIDTH-1:0] pg_d;
    pg_t [WIDTH-1:0] pg_q;
    logic            valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i >= DIST) begin : g_black
            assign pg_d[i] = ks_black(pg_i[i], pg_i[i-DIST]);
        end else begin : g_pass
            assign pg_d[i] = pg_i[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pg_q    <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            pg_q    <= pg_d;
        end
    end

    assign valid_o = valid_q;
    assign pg_o    = pg_q;

endmodule

// File: rtl/ks_pipe_subtractor.sv
// rtl/ks_pipe_subtractor.sv - pipelined Kogge-Stone subtractor diff = a - b - bin
// Optional KS_SUB_SAT_EN: clamp diff to signed max/min on signed overflow.
module ks_pipe_subtractor
    import ks_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    logic             en;
    logic             s0_valid_q;
    logic [WIDTH-1:0] s0_p_q;
    logic [WIDTH-1:0] s0_g_q;
    logic             s0_cin_q;

    pg_t [WIDTH-1:0]  pg0;
    pg_t [WIDTH-1:0]  lvl_pg    [0:LEVELS];
    logic             lvl_valid [0:LEVELS];

    // p and cin ride alongside the prefix levels so the final stage sees them aligned.
    logic [WIDTH-1:0] p_pipe_q  [0:LEVELS-1];
    logic [LEVELS-1:0] cin_pipe_q;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_raw;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d;
    logic             ovf_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    // One global enable: the whole pipe advances or the whole pipe holds.
    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_p_q     <= '0;
            s0_g_q     <= '0;
            s0_cin_q   <= 1'b0;
        end else if (en) begin
            s0_valid_q <= in_valid;
            s0_p_q     <= a ^ ~b;
            s0_g_q     <= a & ~b;
            s0_cin_q   <= ~bin;
        end
    end

    always_comb begin
        pg0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pg0[i].g = s0_g_q[i];
            pg0[i].p = s0_p_q[i];
        end
    end

    assign lvl_pg[0]    = pg0;
    assign lvl_valid[0] = s0_valid_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .valid_i (lvl_valid[k]),
            .pg_i    (lvl_pg[k]),
            .valid_o (lvl_valid[k+1]),
            .pg_o    (lvl_pg[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEVELS; k++) p_pipe_q[k] <= '0;
            cin_pipe_q <= '0;
        end else if (en) begin
            p_pipe_q[0] <= s0_p_q;
            for (int k = 1; k < LEVELS; k++) p_pipe_q[k] <= p_pipe_q[k-1];
            cin_pipe_q <= {cin_pipe_q[LEVELS-2:0], s0_cin_q};
        end
    end

    // cin is applied after the prefix tree: carry[i] = G[i:0] | P[i:0] & cin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i] = lvl_pg[LEVELS][i].g | (lvl_pg[LEVELS][i].p & cin_pipe_q[LEVELS-1]);
    end

    assign diff_raw = p_pipe_q[LEVELS-1] ^ {carry[WIDTH-2:0], cin_pipe_q[LEVELS-1]};
    assign borrow_d = ~carry[WIDTH-1];
    assign ovf_d    = carry[WIDTH-1] ^ carry[WIDTH-2];

`ifdef KS_SUB_SAT_EN
    // On overflow the wrapped MSB is the inverse of a's sign, so it picks the clamp.
    assign diff_d = !ovf_d ? diff_raw
                  : diff_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                  : {1'b1, {(WIDTH-1){1'b0}}};
`else
    assign diff_d = diff_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= lvl_valid[LEVELS];
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule
